// File: rtl/gesture_cmd_scheduler.sv
// gesture_cmd_scheduler
// Arbitrates level-high requests from the gesture detector bank and grants one
// gesture at a time by fixed priority, with bit 0 (off) as the highest priority.
// The granted command code (index + 1) is offered to the radio link over a
// valid/ready handshake. On acceptance the granted detector gets a one-cycle
// clear pulse and a hold-off window starts. An off request may pre-empt a
// hold-off that followed any other grant. An accepted off command latches
// off_latched_o, which blocks further grants until armed_i rises again. An
// offer that is not accepted within ACK_TIMEOUT cycles is withdrawn and sets the
// sticky ack_err_o.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   armed_i        scheduler enable; a rising edge clears off_latched_o
//   gesture_req_i  detector outputs, bit 0 = off, level-high
//   cmd_ready_i    transmitter accepts cmd_code_o this cycle
//   cmd_valid_o    command offered
//   cmd_code_o     command code, stable while cmd_valid_o = 1
//   fsm_clear_o    one-cycle clear pulse to the granted detector
//   busy_o         1 whenever the scheduler is not idle
//   off_latched_o  set when an off command is accepted
//   ack_err_o      sticky: an offer was withdrawn by the acknowledge timeout
module gesture_cmd_scheduler #(
    parameter int unsigned N_GEST      = 4,
    parameter int unsigned CMD_W       = 4,
    parameter int unsigned HOLDOFF     = 65000000,
    parameter int unsigned ACK_TIMEOUT = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              armed_i,
    input  logic [N_GEST-1:0] gesture_req_i,
    input  logic              cmd_ready_i,
    output logic              cmd_valid_o,
    output logic [CMD_W-1:0]  cmd_code_o,
    output logic [N_GEST-1:0] fsm_clear_o,
    output logic              busy_o,
    output logic              off_latched_o,
    output logic              ack_err_o
);

    localparam int unsigned MAX_CNT = (HOLDOFF > ACK_TIMEOUT) ? HOLDOFF : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int unsigned WIN_W   = (N_GEST > 1) ? $clog2(N_GEST) : 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic                valid_q, valid_d;
    logic [CMD_W-1:0]    code_q, code_d;
    logic [N_GEST-1:0]   clear_q, clear_d;
    logic                busy_q, busy_d;
    logic                off_q, off_d;
    logic                err_q, err_d;
    logic                armed_q;

    logic                armed_rise;
    logic                latch_eff;
    logic                req_any;
    logic                found;
    logic [WIN_W-1:0]    win_idx;

    // Fixed-priority encoder: the lowest set request index wins.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_GEST; i++) begin
            if (!found && gesture_req_i[i]) begin
                win_idx = WIN_W'(i);
                found   = 1'b1;
            end
        end
    end

    assign req_any    = |gesture_req_i;
    assign armed_rise = armed_i & ~armed_q;
    // A rising edge of armed releases the off latch in the same cycle, so a
    // pending request can be granted on that very edge.
    assign latch_eff  = off_q & ~armed_rise;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        valid_d = valid_q;
        code_d  = code_q;
        clear_d = '0;
        off_d   = armed_rise ? 1'b0 : off_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (armed_i && !latch_eff && req_any) begin
                    state_d = S_ISSUE;
                    win_d   = win_idx;
                    valid_d = 1'b1;
                    code_d  = CMD_W'(win_idx) + CMD_W'(1);
                    cnt_d   = '0;
                end
            end

            S_ISSUE: begin
                if (cmd_ready_i) begin
                    state_d = S_HOLD;
                    valid_d = 1'b0;
                    code_d  = '0;
                    clear_d = N_GEST'(1) << win_q;
                    if (win_q == '0) begin
                        off_d = 1'b1;
                    end
                    cnt_d   = HOLD_LOAD;
                end else if (cnt_q == ACK_LAST) begin
                    // Offer has been visible for ACK_TIMEOUT cycles: withdraw it
                    // without clearing the detector so it can be re-offered.
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    code_d  = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_HOLD: begin
                if (gesture_req_i[0] && (win_q != '0)) begin
                    // Off pre-empts the hold-off of any other command.
                    state_d = S_ISSUE;
                    win_d   = '0;
                    valid_d = 1'b1;
                    code_d  = CMD_W'(1);
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                code_d  = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            clear_q <= '0;
            busy_q  <= 1'b0;
            off_q   <= 1'b0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
            off_q   <= off_d;
            err_q   <= err_d;
            armed_q <= armed_i;
        end
    end

    assign cmd_valid_o   = valid_q;
    assign cmd_code_o    = code_q;
    assign fsm_clear_o   = clear_q;
    assign busy_o        = busy_q;
    assign off_latched_o = off_q;
    assign ack_err_o     = err_q;

endmodule

// File: tb/tb_gesture_cmd_scheduler.sv
// Testbench for gesture_cmd_scheduler (N_GEST=4, HOLDOFF=8, ACK_TIMEOUT=16).
// Expected command codes are queued when a handshake is set up and compared
// against cmd_code when the bench sees cmd_valid & cmd_ready; timing and
// side-effect outputs are checked directly from the main sequence.
module tb_gesture_cmd_scheduler;

    localparam int unsigned N_GEST      = 4;
    localparam int unsigned CMD_W       = 4;
    localparam int unsigned HOLDOFF     = 8;
    localparam int unsigned ACK_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              armed;
    logic [N_GEST-1:0] req;
    logic              ready;
    logic              cmd_valid;
    logic [CMD_W-1:0]  cmd_code;
    logic [N_GEST-1:0] fsm_clear;
    logic              busy;
    logic              off_latched;
    logic              ack_err;

    gesture_cmd_scheduler #(
        .N_GEST      (N_GEST),
        .CMD_W       (CMD_W),
        .HOLDOFF     (HOLDOFF),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .armed_i       (armed),
        .gesture_req_i (req),
        .cmd_ready_i   (ready),
        .cmd_valid_o   (cmd_valid),
        .cmd_code_o    (cmd_code),
        .fsm_clear_o   (fsm_clear),
        .busy_o        (busy),
        .off_latched_o (off_latched),
        .ack_err_o     (ack_err)
    );

    always #5 clk = ~clk;

    int unsigned      n_tests = 0;
    int unsigned      n_fail  = 0;
    logic [CMD_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_offer(input string tag, input logic [CMD_W-1:0] code);
        check_eq({tag, " valid"}, 32'(cmd_valid), 32'd1);
        check_eq({tag, " code"}, 32'(cmd_code), 32'(code));
        check_eq({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int n = 0;
        while (!cmd_valid && n < maxc) begin
            tick();
            n++;
        end
        check_eq({tag, " valid within bound"}, 32'(cmd_valid), 32'd1);
    endtask

    task automatic wait_busy_low(input string tag, input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            tick();
            n++;
        end
        check_eq({tag, " idle within bound"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {19'd0, cmd_valid, cmd_code, fsm_clear, busy, off_latched, ack_err}, 32'd0);
    endtask

    task automatic hold_sequence(input string tag);
        // Called at the first HOLD cycle: busy must last exactly HOLDOFF cycles.
        check_eq({tag, " busy hold 1"}, 32'(busy), 32'd1);
        for (int unsigned i = 1; i < HOLDOFF; i++) begin
            tick();
            check_eq({tag, " busy hold"}, 32'(busy), 32'd1);
            if (i == 1) check_eq({tag, " clear one cycle"}, 32'(fsm_clear), 32'd0);
        end
        tick();
        check_eq({tag, " idle after hold"}, 32'(busy), 32'd0);
    endtask

    // Scoreboard: compare code at every handshake, sampled mid-cycle.
    always begin
        logic [CMD_W-1:0] e;
        @(negedge clk);
        #4;
        if (rst_n && cmd_valid && ready) begin
            e = 'x;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            check_eq("sb code", 32'(cmd_code), 32'(e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int nv;
        logic [N_GEST-1:0] clr_or;

        rst_n = 1'b0;
        armed = 1'b0;
        ready = 1'b0;
        req   = '0;
        repeat (2) tick();
        check_all_zero("reset state");
        rst_n = 1'b1;
        tick();

        // 1: single request, ready tied high
        armed = 1'b1;
        ready = 1'b1;
        req   = 4'b0100;
        exp_q.push_back(4'd3);
        tick();
        expect_offer("s1 offer", 4'd3);
        req = '0;
        tick();
        check_eq("s1 valid drop", 32'(cmd_valid), 32'd0);
        check_eq("s1 clear", 32'(fsm_clear), 32'b0100);
        hold_sequence("s1");

        // 2: two requests, ready delayed
        ready = 1'b0;
        req   = 4'b1010;
        tick();
        expect_offer("s2 offer", 4'd2);
        repeat (2) begin
            tick();
            check_eq("s2 valid stable", 32'(cmd_valid), 32'd1);
            check_eq("s2 code stable", 32'(cmd_code), 32'd2);
        end
        exp_q.push_back(4'd2);
        ready = 1'b1;
        tick();
        check_eq("s2 clear only bit1", 32'(fsm_clear), 32'b0010);
        check_eq("s2 valid drop", 32'(cmd_valid), 32'd0);
        req = 4'b1000;
        exp_q.push_back(4'd4);
        wait_valid("s2 regrant", 20);
        check_eq("s2 regrant code", 32'(cmd_code), 32'd4);
        req = '0;
        tick();
        check_eq("s2 clear bit3", 32'(fsm_clear), 32'b1000);
        wait_busy_low("s2", 20);

        // 3: off pre-empts hold-off, then latches
        req = 4'b0100;
        exp_q.push_back(4'd3);
        tick();
        expect_offer("s3 offer", 4'd3);
        req = '0;
        tick();
        check_eq("s3 clear", 32'(fsm_clear), 32'b0100);
        tick();
        check_eq("s3 hold cycle 2", 32'(busy), 32'd1);
        req = 4'b0001;
        exp_q.push_back(4'd1);
        tick();
        expect_offer("s3 preempt", 4'd1);
        tick();
        check_eq("s3 off clear", 32'(fsm_clear), 32'b0001);
        check_eq("s3 off latched", 32'(off_latched), 32'd1);
        req = '0;
        wait_busy_low("s3", 20);
        req  = 4'b0100;
        seen = 0;
        repeat (12) begin
            tick();
            seen += int'(cmd_valid);
        end
        check_eq("s3 latch blocks grants", 32'(seen), 32'd0);
        armed = 1'b0;
        tick();
        armed = 1'b1;
        exp_q.push_back(4'd3);
        tick();
        expect_offer("s3 rearm offer", 4'd3);
        check_eq("s3 latch cleared", 32'(off_latched), 32'd0);
        req = '0;
        tick();
        wait_busy_low("s3 rearm", 20);

        // 4: acknowledge timeout
        ready = 1'b0;
        req   = 4'b0001;
        tick();
        expect_offer("s4 offer", 4'd1);
        nv     = 1;
        clr_or = '0;
        while (cmd_valid && nv < 40) begin
            tick();
            clr_or |= fsm_clear;
            if (cmd_valid) nv++;
        end
        check_eq("s4 valid cycles", 32'(nv), 32'(ACK_TIMEOUT));
        check_eq("s4 valid dropped", 32'(cmd_valid), 32'd0);
        check_eq("s4 ack_err", 32'(ack_err), 32'd1);
        check_eq("s4 idle", 32'(busy), 32'd0);
        check_eq("s4 no clear", 32'(clr_or), 32'd0);
        tick();
        expect_offer("s4 reoffer", 4'd1);
        exp_q.push_back(4'd1);
        ready = 1'b1;
        tick();
        check_eq("s4 clear", 32'(fsm_clear), 32'b0001);
        check_eq("s4 off latched", 32'(off_latched), 32'd1);
        req = '0;
        wait_busy_low("s4", 20);

        // 5: disarmed with all requests pending
        armed = 1'b0;
        req   = 4'b1111;
        repeat (4) begin
            tick();
            check_eq("s5 disarmed valid", 32'(cmd_valid), 32'd0);
            check_eq("s5 disarmed busy", 32'(busy), 32'd0);
        end
        armed = 1'b1;
        exp_q.push_back(4'd1);
        tick();
        expect_offer("s5 armed offer", 4'd1);
        req = 4'b1110;
        tick();
        check_eq("s5 clear", 32'(fsm_clear), 32'b0001);
        wait_busy_low("s5", 20);
        req = '0;
        check_eq("s5 ack_err sticky", 32'(ack_err), 32'd1);

        // 6: reset mid-ISSUE and mid-HOLD
        armed = 1'b0;
        tick();
        armed = 1'b1;
        ready = 1'b0;
        req   = 4'b0100;
        tick();
        expect_offer("s6 offer", 4'd3);
        #2 rst_n = 1'b0;
        #1 check_all_zero("s6 reset in issue");
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        exp_q.push_back(4'd3);
        tick();
        expect_offer("s6 post-reset offer", 4'd3);
        req = '0;
        tick();
        check_eq("s6 clear", 32'(fsm_clear), 32'b0100);
        tick();
        check_eq("s6 hold busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("s6 reset in hold");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("s6 idle after reset", 32'(busy), 32'd0);
        req = 4'b0100;
        exp_q.push_back(4'd3);
        tick();
        expect_offer("s6 fresh offer", 4'd3);
        req = '0;
        tick();
        check_eq("s6 fresh clear", 32'(fsm_clear), 32'b0100);
        hold_sequence("s6 fresh");

        check_eq("sb drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
